dsp: RTL and testbench
======================

DSP -- requirements
Module: dsp

Interface
REQ-001 Parameter IMEM_DEPTH, default 4096, instruction words (16-bit).
REQ-002 Parameter DMEM_DEPTH, default 256, data words (16-bit).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_out  output  12  current program counter.
REQ-006 acc_out  output  32  accumulator.
REQ-007 No other ports; all outputs are directly driven by registers.

Function
REQ-008 Architecture: TMS32010-style, single-cycle, non-pipelined; each clock fetches InstrMem.mem[pc], executes it, and sets pc to pc+1, wrapping at IMEM_DEPTH.
REQ-009 Registers: ACC 32b, T 16b, P 32b, DP 1b, PC 12b.
REQ-010 Direct addressing: data address = {DP, instr[6:0]}; instr[7] is ignored (no indirect mode).
REQ-011 Data memory read is combinational; data memory write is synchronous on the same edge that retires the instruction.
REQ-012 Arithmetic is 32-bit two's complement and wraps modulo 2^32; there is no saturation and no overflow flag.
REQ-013 Notation: sext(m) is the 16-bit memory word sign-extended to 32 bits; S is instr[11:8].
REQ-014 ADD 0000SSSS0ddddddd: ACC += sext(m)<<S.
REQ-015 SUB 0001SSSS0ddddddd: ACC -= sext(m)<<S.
REQ-016 LAC 0010SSSS0ddddddd: ACC = sext(m)<<S.
REQ-017 SACL 01010000 0ddddddd: mem = ACC[15:0].
REQ-018 SACH 01011SSS 0ddddddd: mem = (ACC<<SSS)[31:16].
REQ-019 Load and add group:
- ADDH 0x60: ACC[31:16] += m; ACC[15:0] unchanged.
- ADDS 0x61: ACC += zero-extended m.
- LT 0x6A: T = m.
- LTA 0x6C: T = m and ACC += P, using the pre-instruction P.
- MPY 0x6D: P = signed T * signed m, full 32-bit product.
- LDP 0x6F: DP = m[0].
- LDPK 0x6E: DP = instr[0].
- The opcode value is the upper byte; the lower byte is the address or constant.
REQ-020 Logic and constant group:
- AND 0x79: ACC = {16'h0, ACC[15:0] & m}.
- OR 0x7A: ACC[15:0] |= m; ACC[31:16] unchanged.
- LACK 0x7E: ACC = zero-extended instr[7:0].
REQ-021 Accumulator and product group:
- ZAC 0x7F89: ACC = 0.
- PAC 0x7F8E: ACC = P.
- APAC 0x7F8F: ACC += P.
- SPAC 0x7F90: ACC -= P.
- NOP 0x7F80: no state change.
REQ-022 Any undefined encoding executes as NOP, and PC still advances.
REQ-023 An instruction writes only the registers and memory its definition names; all other state holds its value.

Reset
REQ-024 While reset is sampled high at a rising clk edge: PC=0, ACC=0, P=0, T=0, DP=0, and no memory write occurs.
REQ-025 Reset does not clear either memory; their contents persist across reset, including a reset asserted mid-program.
REQ-026 The first clock edge after reset is released executes the instruction at address 0.

Structure
REQ-027 Package dsp_pkg holds:
- the opcode constants;
- the word width (16), accumulator width (32), and PC width (12).
REQ-028 One sub-module dsp_ram(DEPTH, WIDTH=16) with internal array mem[0:DEPTH-1], asynchronous read, and synchronous write-enable.
REQ-029 dsp_ram instantiation:
- instance InstrMem, with write tied off;
- instance DataMem;
- these instance names and the member name mem are fixed, so benches can preload via $readmemb on dsp.InstrMem.mem and dsp.DataMem.mem.
REQ-030 The ALU and decode are a single combinational block inside dsp; the design is 120-400 lines of RTL.

Verification
REQ-031 Reset, then LACK 0x05, then ADD shift 4 with mem[0x10]=0x0003 -> ACC=0x00000035.
REQ-032 LT with mem=0xFFFE (-2), then MPY with mem=0x0007 -> P=0xFFFFFFF2; then PAC, APAC -> ACC=0xFFFFFFE4; then SPAC -> ACC=0xFFFFFFF2.
REQ-033 Logic and add-high sequence, checked after each instruction:
- start ACC=0x1234ABCD;
- AND m=0x0F0F -> 0x00000B0D;
- OR m=0xF000 -> 0x0000FB0D;
- ADDH m=0x0001 -> 0x0001FB0D;
- ADDS m=0x8000 -> 0x00027B0D.
REQ-034 Page select and store:
- LDPK 1, then SACL to dma 0x05 -> DataMem.mem[0x85] = ACC[15:0];
- mem[0x05] is unchanged;
- SACH shift 0 stores ACC[31:16].
REQ-035 Reset during execution:
- set ACC and T to nonzero values, then assert reset for one cycle;
- every register reads 0 and PC=0;
- DataMem retains its prior contents;
- execution restarts at address 0.
REQ-036 LTA with P=0x00000010, ACC=1 and mem=0x0009 -> T=0x0009, ACC=0x00000011.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared widths, opcode encodings and the instruction decoder for the dsp core.
package dsp_pkg;

  localparam int WORD_W = 16;
  localparam int ACC_W  = 32;
  localparam int PC_W   = 12;

  localparam logic [3:0]  OP_ADD  = 4'h0;
  localparam logic [3:0]  OP_SUB  = 4'h1;
  localparam logic [3:0]  OP_LAC  = 4'h2;
  localparam logic [7:0]  OP_SACL = 8'h50;
  localparam logic [4:0]  OP_SACH = 5'b01011;
  localparam logic [7:0]  OP_ADDH = 8'h60;
  localparam logic [7:0]  OP_ADDS = 8'h61;
  localparam logic [7:0]  OP_LT   = 8'h6A;
  localparam logic [7:0]  OP_LTA  = 8'h6C;
  localparam logic [7:0]  OP_MPY  = 8'h6D;
  localparam logic [7:0]  OP_LDPK = 8'h6E;
  localparam logic [7:0]  OP_LDP  = 8'h6F;
  localparam logic [7:0]  OP_AND  = 8'h79;
  localparam logic [7:0]  OP_OR   = 8'h7A;
  localparam logic [7:0]  OP_LACK = 8'h7E;
  localparam logic [15:0] OP_NOP  = 16'h7F80;
  localparam logic [15:0] OP_ZAC  = 16'h7F89;
  localparam logic [15:0] OP_PAC  = 16'h7F8E;
  localparam logic [15:0] OP_APAC = 16'h7F8F;
  localparam logic [15:0] OP_SPAC = 16'h7F90;

  typedef enum logic [4:0] {
    I_NOP, I_ADD, I_SUB, I_LAC, I_SACL, I_SACH, I_ADDH, I_ADDS, I_LT, I_LTA,
    I_MPY, I_LDP, I_LDPK, I_AND, I_OR, I_LACK, I_ZAC, I_PAC, I_APAC, I_SPAC
  } op_e;

  // Anything not matched here falls through to I_NOP.
  function automatic op_e decode(input logic [WORD_W-1:0] ins);
    op_e op;
    op = I_NOP;
    if      (ins[15:12] == OP_ADD)  op = I_ADD;
    else if (ins[15:12] == OP_SUB)  op = I_SUB;
    else if (ins[15:12] == OP_LAC)  op = I_LAC;
    else if (ins[15:8]  == OP_SACL) op = I_SACL;
    else if (ins[15:11] == OP_SACH) op = I_SACH;
    else if (ins[15:8]  == OP_ADDH) op = I_ADDH;
    else if (ins[15:8]  == OP_ADDS) op = I_ADDS;
    else if (ins[15:8]  == OP_LT)   op = I_LT;
    else if (ins[15:8]  == OP_LTA)  op = I_LTA;
    else if (ins[15:8]  == OP_MPY)  op = I_MPY;
    else if (ins[15:8]  == OP_LDPK) op = I_LDPK;
    else if (ins[15:8]  == OP_LDP)  op = I_LDP;
    else if (ins[15:8]  == OP_AND)  op = I_AND;
    else if (ins[15:8]  == OP_OR)   op = I_OR;
    else if (ins[15:8]  == OP_LACK) op = I_LACK;
    else if (ins == OP_ZAC)         op = I_ZAC;
    else if (ins == OP_PAC)         op = I_PAC;
    else if (ins == OP_APAC)        op = I_APAC;
    else if (ins == OP_SPAC)        op = I_SPAC;
    return op;
  endfunction

endpackage

// File: rtl/dsp_ram.sv
// Word-wide RAM with combinational read and synchronous write; no reset so
// contents survive a core reset.
module dsp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/dsp.sv
// Single-cycle TMS32010-style core: fetch, decode and execute one instruction
// per clock from InstrMem, with direct-page data addressing into DataMem.
module dsp
  import dsp_pkg::*;
#(
  parameter int IMEM_DEPTH = 4096,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   pc_out,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [PC_W-1:0]   pc, pc_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W-1:0]  p, p_nxt;
  logic [WORD_W-1:0] t, t_nxt;
  logic              dp, dp_nxt;

  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] m;
  logic [7:0]        dma;
  logic              dm_we;
  logic [WORD_W-1:0] dm_wdata;

  op_e               op;
  logic [ACC_W-1:0]  m_sx, m_shift, sach_val, prod;

  assign dma = {dp, instr[6:0]};

  dsp_ram #(.DEPTH(IMEM_DEPTH), .WIDTH(WORD_W)) InstrMem (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[IAW-1:0]),
    .wdata ({WORD_W{1'b0}}),
    .rdata (instr)
  );

  dsp_ram #(.DEPTH(DMEM_DEPTH), .WIDTH(WORD_W)) DataMem (
    .clk   (clk),
    .we    (dm_we),
    .addr  (dma[DAW-1:0]),
    .wdata (dm_wdata),
    .rdata (m)
  );

  assign pc_nxt = (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + PC_W'(1);

  always_comb begin
    op       = decode(instr);
    m_sx     = {{(ACC_W-WORD_W){m[WORD_W-1]}}, m};
    m_shift  = m_sx << instr[11:8];
    sach_val = acc << instr[10:8];
    prod     = $signed({{(ACC_W-WORD_W){t[WORD_W-1]}}, t}) * $signed(m_sx);

    acc_nxt  = acc;
    t_nxt    = t;
    p_nxt    = p;
    dp_nxt   = dp;
    dm_we    = 1'b0;
    dm_wdata = acc[15:0];

    case (op)
      I_ADD:  acc_nxt = acc + m_shift;
      I_SUB:  acc_nxt = acc - m_shift;
      I_LAC:  acc_nxt = m_shift;
      I_SACL: begin
        dm_we    = ~reset;
        dm_wdata = acc[15:0];
      end
      I_SACH: begin
        dm_we    = ~reset;
        dm_wdata = sach_val[31:16];
      end
      I_ADDH: acc_nxt = {acc[31:16] + m, acc[15:0]};
      I_ADDS: acc_nxt = acc + {16'h0, m};
      I_LT:   t_nxt   = m;
      I_LTA: begin
        t_nxt   = m;
        acc_nxt = acc + p;
      end
      I_MPY:  p_nxt   = prod;
      I_LDP:  dp_nxt  = m[0];
      I_LDPK: dp_nxt  = instr[0];
      I_AND:  acc_nxt = {16'h0, acc[15:0] & m};
      I_OR:   acc_nxt = {acc[31:16], acc[15:0] | m};
      I_LACK: acc_nxt = {24'h0, instr[7:0]};
      I_ZAC:  acc_nxt = '0;
      I_PAC:  acc_nxt = p;
      I_APAC: acc_nxt = acc + p;
      I_SPAC: acc_nxt = acc - p;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      acc <= '0;
      p   <= '0;
      t   <= '0;
      dp  <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      acc <= acc_nxt;
      p   <= p_nxt;
      t   <= t_nxt;
      dp  <= dp_nxt;
    end
  end

  assign pc_out  = pc;
  assign acc_out = acc;

endmodule

// File: tb/tb_dsp.sv
// Self-checking bench for dsp: programs are preloaded per scenario and the
// expected pc/acc after each retired instruction is queued as it is loaded.
module tb_dsp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pc_out;
  logic [31:0] acc_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];
  int   load_pc;

  always #5 clk = ~clk;

  dsp dut (
    .clk     (clk),
    .reset   (reset),
    .pc_out  (pc_out),
    .acc_out (acc_out)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic start_prog();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) dut.InstrMem.mem[i] = 16'h7F80;
    load_pc = 0;
    sb.delete();
  endtask

  task automatic put(input logic [15:0] ins, input string n, input logic [31:0] a);
    exp_t e;
    dut.InstrMem.mem[load_pc] = ins;
    load_pc++;
    e.name = n;
    e.pc   = 12'(load_pc);
    e.acc  = a;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 12'h000) begin failures++; $display("FAIL reset_pc: got %h want 000", pc_out); end
    checks++;
    if (acc_out !== 32'h0) begin failures++; $display("FAIL reset_acc: got %h want 00000000", acc_out); end
    checks++;
    if (dut.t !== 16'h0 || dut.p !== 32'h0 || dut.dp !== 1'b0) begin
      failures++; $display("FAIL reset_tpdp: t=%h p=%h dp=%b want all zero", dut.t, dut.p, dut.dp);
    end
    for (int i = 0; i < 4096; i++) dut.InstrMem.mem[i] = 16'h7F80;
    reset = 1'b0;
    repeat (4095) @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 12'hFFF || acc_out !== 32'h0) begin
      failures++; $display("FAIL pc_last: pc=%h acc=%h want pc=fff acc=0", pc_out, acc_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 12'h000) begin failures++; $display("FAIL pc_wrap: got %h want 000", pc_out); end
  endtask

  task automatic test_add_shift();
    start_prog();
    dut.DataMem.mem[8'h00] = 16'hCAFE;
    dut.DataMem.mem[8'h10] = 16'h0003;
    dut.DataMem.mem[8'h11] = 16'h0001;
    dut.DataMem.mem[8'h12] = 16'hFF80;
    put(16'h7E05, "lack5",      32'h0000_0005);
    put(16'h0410, "add_s4",     32'h0000_0035);
    put(16'h1010, "sub_s0",     32'h0000_0032);
    put(16'h2F11, "lac_s15",    32'h0000_8000);
    put(16'h2812, "lac_neg_s8", 32'hFFFF_8000);
    put(16'h7F81, "undef_7f81", 32'hFFFF_8000);
    put(16'h6B00, "undef_6b",   32'hFFFF_8000);
    put(16'h5100, "undef_51",   32'hFFFF_8000);
    reset = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
    checks++;
    if (dut.DataMem.mem[8'h00] !== 16'hCAFE) begin
      failures++; $display("FAIL undef_nowrite: mem[00]=%h want cafe", dut.DataMem.mem[8'h00]);
    end
  endtask

  task automatic test_multiply();
    start_prog();
    dut.DataMem.mem[8'h20] = 16'hFFFE;
    dut.DataMem.mem[8'h21] = 16'h0007;
    put(16'h6A20, "lt_m2",   32'h0000_0000);
    put(16'h6D21, "mpy_7",   32'h0000_0000);
    put(16'h7F8E, "pac",     32'hFFFF_FFF2);
    put(16'h7F8F, "apac",    32'hFFFF_FFE4);
    put(16'h7F90, "spac",    32'hFFFF_FFF2);
    reset = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
    checks++;
    if (dut.p !== 32'hFFFF_FFF2 || dut.t !== 16'hFFFE) begin
      failures++; $display("FAIL mpy_regs: p=%h t=%h want p=fffffff2 t=fffe", dut.p, dut.t);
    end
  endtask

  task automatic test_logic_addh();
    start_prog();
    dut.DataMem.mem[8'h30] = 16'h1234;
    dut.DataMem.mem[8'h31] = 16'hABCD;
    dut.DataMem.mem[8'h32] = 16'h0F0F;
    dut.DataMem.mem[8'h33] = 16'hF000;
    dut.DataMem.mem[8'h34] = 16'h0001;
    dut.DataMem.mem[8'h35] = 16'h8000;
    dut.DataMem.mem[8'h36] = 16'hFFFF;
    put(16'h6030, "addh_1234",   32'h1234_0000);
    put(16'h6131, "adds_abcd",   32'h1234_ABCD);
    put(16'h7932, "and_0f0f",    32'h0000_0B0D);
    put(16'h7A33, "or_f000",     32'h0000_FB0D);
    put(16'h6034, "addh_1",      32'h0001_FB0D);
    put(16'h6135, "adds_8000",   32'h0002_7B0D);
    put(16'h6036, "addh_wrap",   32'h0001_7B0D);
    put(16'h61B5, "adds_bit7",   32'h0001_FB0D);
    reset = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
  endtask

  task automatic test_page_store();
    start_prog();
    dut.DataMem.mem[8'h40] = 16'hBEEF;
    dut.DataMem.mem[8'h41] = 16'h1234;
    dut.DataMem.mem[8'h05] = 16'h5555;
    dut.DataMem.mem[8'h85] = 16'h0000;
    dut.DataMem.mem[8'h86] = 16'h0000;
    dut.DataMem.mem[8'h87] = 16'h0000;
    dut.DataMem.mem[8'h88] = 16'h0002;
    dut.DataMem.mem[8'h09] = 16'h0000;
    dut.DataMem.mem[8'h89] = 16'h7777;
    put(16'h6040, "pg_addh",  32'hBEEF_0000);
    put(16'h6141, "pg_adds",  32'hBEEF_1234);
    put(16'h6E01, "ldpk1",    32'hBEEF_1234);
    put(16'h5005, "sacl_85",  32'hBEEF_1234);
    put(16'h5806, "sach0_86", 32'hBEEF_1234);
    put(16'h5C07, "sach4_87", 32'hBEEF_1234);
    put(16'h6F08, "ldp_88",   32'hBEEF_1234);
    put(16'h5009, "sacl_09",  32'hBEEF_1234);
    reset = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
    checks++;
    if (dut.DataMem.mem[8'h85] !== 16'h1234) begin failures++; $display("FAIL sacl_page1: mem[85]=%h want 1234", dut.DataMem.mem[8'h85]); end
    checks++;
    if (dut.DataMem.mem[8'h05] !== 16'h5555) begin failures++; $display("FAIL page0_kept: mem[05]=%h want 5555", dut.DataMem.mem[8'h05]); end
    checks++;
    if (dut.DataMem.mem[8'h86] !== 16'hBEEF) begin failures++; $display("FAIL sach_s0: mem[86]=%h want beef", dut.DataMem.mem[8'h86]); end
    checks++;
    if (dut.DataMem.mem[8'h87] !== 16'hEEF1) begin failures++; $display("FAIL sach_s4: mem[87]=%h want eef1", dut.DataMem.mem[8'h87]); end
    checks++;
    if (dut.DataMem.mem[8'h09] !== 16'h1234 || dut.DataMem.mem[8'h89] !== 16'h7777) begin
      failures++; $display("FAIL ldp_page0: mem[09]=%h mem[89]=%h want 1234 7777", dut.DataMem.mem[8'h09], dut.DataMem.mem[8'h89]);
    end
  endtask

  task automatic test_lta();
    start_prog();
    dut.DataMem.mem[8'h50] = 16'h0004;
    dut.DataMem.mem[8'h51] = 16'h0009;
    put(16'h6A50, "lt_4",     32'h0000_0000);
    put(16'h6D50, "mpy_4x4",  32'h0000_0000);
    put(16'h7E01, "lack1",    32'h0000_0001);
    put(16'h6C51, "lta_9",    32'h0000_0011);
    put(16'h6D51, "mpy_9x9",  32'h0000_0011);
    put(16'h7F8E, "pac_81",   32'h0000_0051);
    put(16'h7F89, "zac",      32'h0000_0000);
    reset = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
    checks++;
    if (dut.t !== 16'h0009) begin failures++; $display("FAIL lta_t: t=%h want 0009", dut.t); end
  endtask

  task automatic test_reset_midrun();
    start_prog();
    dut.DataMem.mem[8'h60] = 16'h00AA;
    dut.DataMem.mem[8'h61] = 16'h0000;
    put(16'h7E33, "mr_lack",  32'h0000_0033);
    put(16'h6A60, "mr_lt",    32'h0000_0033);
    put(16'h6D60, "mr_mpy",   32'h0000_0033);
    put(16'h5061, "mr_sacl",  32'h0000_0033);
    put(16'h6E01, "mr_ldpk",  32'h0000_0033);
    reset = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
    checks++;
    if (dut.t !== 16'h00AA || dut.p !== 32'h0000_70E4 || dut.dp !== 1'b1) begin
      failures++; $display("FAIL mr_pre: t=%h p=%h dp=%b want 00aa 000070e4 1", dut.t, dut.p, dut.dp);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (pc_out !== 12'h0 || acc_out !== 32'h0 || dut.t !== 16'h0 || dut.p !== 32'h0 || dut.dp !== 1'b0) begin
      failures++;
      $display("FAIL mr_regs: pc=%h acc=%h t=%h p=%h dp=%b want all zero", pc_out, acc_out, dut.t, dut.p, dut.dp);
    end
    checks++;
    if (dut.DataMem.mem[8'h61] !== 16'h0033) begin
      failures++; $display("FAIL mr_mem_kept: mem[61]=%h want 0033", dut.DataMem.mem[8'h61]);
    end
    load_pc = 0;
    put(16'h7E33, "mr_restart", 32'h0000_0033);
    while (sb.size() > 0) begin
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (acc_out !== e.acc || pc_out !== e.pc) begin
        failures++;
        $display("FAIL %s: pc=%h acc=%h want pc=%h acc=%h", e.name, pc_out, acc_out, e.pc, e.acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_shift();
    test_multiply();
    test_logic_addh();
    test_page_store();
    test_lta();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
